uart_burst_rx: RTL and testbench

Serial receiver for the UARTB link. It is the receive-side counterpart of the burst-capable transmitter. It deserialises 8N1 frames from rxd. In normal mode it presents one byte per frame; in burst mode it assembles four consecutive frames, LSB byte first, into one 32-bit word. It sits between the rxd pin (or the txd loopback) and the CPU read path, and uses the same divider/mode values that the CPU writes to the BRG/mode register.

---
 rtl/uart_burst_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_burst_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_burst_rx.sv
// UARTB receiver: 8N1 deserialiser with a byte mode and a 4-frame burst mode (32-bit word).
module uart_burst_rx #(
  parameter int unsigned DIV_W       = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divider,
  input  logic             mode,
  input  logic             rd,
  output logic [31:0]      q,
  output logic             dv,
  output logic             ovf,
  output logic             ferr,
  output logic             rxbusy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic             mode_l_q, mode_l_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      word_q, word_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic             fe_pend_q, fe_pend_d;
  logic [31:0]      q_q, q_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic [DIV_W-1:0] div_start;
  logic [DIV_W:0]   period;
  logic [DIV_W:0]   half_m1_w;

  assign rs = sync_q[SYNC_STAGES-1];

  // rxd synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  // Divider only follows the input when a new word starts; mid-word the latched value is kept
  always_comb begin
    div_start = (byte_cnt_q == 2'd0) ? divider : div_l_q;
    period    = {1'b0, div_start} + {{DIV_W{1'b0}}, 1'b1};
    half_m1_w = (period >> 1) - {{DIV_W{1'b0}}, 1'b1};
  end

  // Receive FSM next-state: bit timing, sampling, lane assembly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    div_l_d     = div_l_q;
    mode_l_d    = mode_l_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    fe_pend_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rs) begin
          state_d = StStart;
          cnt_d   = half_m1_w[DIV_W-1:0];
          if (byte_cnt_q == 2'd0) begin
            div_l_d  = divider;
            mode_l_d = mode;
          end
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rs) begin
            state_d   = StData;
            cnt_d     = div_l_q;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d[bit_idx_q] = rs;
          cnt_d              = div_l_q;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rs) begin
            state_d = StIdle;
            if (mode_l_q) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              unique case (byte_cnt_q)
                2'd0: word_d[7:0]   = shift_q;
                2'd1: word_d[15:8]  = shift_q;
                2'd2: word_d[23:16] = shift_q;
                default: begin
                  pend_d      = 1'b1;
                  pend_data_d = {shift_q, word_q};
                end
              endcase
            end else begin
              pend_d      = 1'b1;
              pend_data_d = {24'h0, shift_q};
            end
          end else begin
            // Framing error drops any partial word
            state_d    = StBreak;
            fe_pend_d  = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StBreak: begin
        if (rs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // CPU-visible results, one clock after the stop-bit sample; completion beats a same-cycle rd
  always_comb begin
    q_d    = pend_q ? pend_data_q : q_q;
    dv_d   = pend_q | (dv_q & ~rd);
    ovf_d  = (ovf_q & ~rd) | (pend_q & dv_q & ~rd);
    ferr_d = fe_pend_q | (ferr_q & ~rd);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h0;
      div_l_q     <= '0;
      mode_l_q    <= 1'b0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'h0;
      pend_q      <= 1'b0;
      pend_data_q <= 32'h0;
      fe_pend_q   <= 1'b0;
      q_q         <= 32'h0;
      dv_q        <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      div_l_q     <= div_l_d;
      mode_l_q    <= mode_l_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      fe_pend_q   <= fe_pend_d;
      q_q         <= q_d;
      dv_q        <= dv_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  assign q      = q_q;
  assign dv     = dv_q;
  assign ovf    = ovf_q;
  assign ferr   = ferr_q;
  assign rxbusy = (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_burst_rx.sv
// Self-checking bench for uart_burst_rx: vector table of frames plus hand-written corner sequences.
module tb_uart_burst_rx;

  localparam int unsigned DivW    = 9;
  localparam int unsigned BitClks = 8;  // divider = 7

  logic            clk = 1'b0;
  logic            reset;
  logic            rxd;
  logic [DivW-1:0] divider;
  logic            mode;
  logic            rd;
  logic [31:0]     q;
  logic            dv, ovf, ferr, rxbusy;

  int checks   = 0;
  int failures = 0;

  uart_burst_rx #(.DIV_W(DivW), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .divider (divider),
    .mode    (mode),
    .rd      (rd),
    .q       (q),
    .dv      (dv),
    .ovf     (ovf),
    .ferr    (ferr),
    .rxbusy  (rxbusy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        dv;
    logic        ovf;
    logic        ferr;
  } exp_t;

  typedef enum int {PreNone, PreGlitch, PreReset} pre_e;

  typedef struct {
    pre_e       pre;
    logic       mode;
    logic [7:0] data;
    logic       stop;
    logic       rd_at_done;
    logic       rd_after;
    int         extra_low;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input pre_e pre, input logic md, input logic [7:0] data,
                              input logic stop, input logic rdd, input logic rda, input int xl,
                              input logic [31:0] eq, input logic edv, input logic eovf,
                              input logic eferr);
    vec_t v;
    v.pre        = pre;
    v.mode       = md;
    v.data       = data;
    v.stop       = stop;
    v.rd_at_done = rdd;
    v.rd_after   = rda;
    v.extra_low  = xl;
    v.exp.q      = eq;
    v.exp.dv     = edv;
    v.exp.ovf    = eovf;
    v.exp.ferr   = eferr;
    return v;
  endfunction

  // Drives one 8N1 frame; compares the popped expectation one clock after rxbusy falls
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_at_done);
    logic prev;
    logic seen;
    int   c;
    exp_t e;
    rxd = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BitClks) @(negedge clk);
    end
    rxd  = stop;
    prev = rxbusy;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 12) begin
      @(negedge clk);
      c++;
      if (prev && !rxbusy) seen = 1'b1;
      else prev = rxbusy;
    end
    if (seen) begin
      if (rd_at_done) rd = 1'b1;
      @(negedge clk);
      c++;
      rd = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = sb.pop_front();
        chk("frame_q", q, e.q);
        chk("frame_dv", 32'(dv), 32'(e.dv));
        chk("frame_ovf", 32'(ovf), 32'(e.ovf));
        chk("frame_ferr", 32'(ferr), 32'(e.ferr));
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL frame_done: rxbusy fall got 0 expected 1");
      if (sb.size() != 0) void'(sb.pop_front());
    end
    while (c < int'(BitClks)) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic pulse_rd_and_check();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("rd_clr_dv", 32'(dv), 32'd0);
    chk("rd_clr_ovf", 32'(ovf), 32'd0);
    chk("rd_clr_ferr", 32'(ferr), 32'd0);
  endtask

  // 60 ns low pulse, shorter than half a bit: must be rejected silently
  task automatic glitch_seq();
    logic any_busy;
    any_busy = 1'b0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (16) begin
      @(negedge clk);
      any_busy |= rxbusy;
    end
    chk("glitch_busy", 32'(any_busy), 32'd0);
    chk("glitch_dv", 32'(dv), 32'd0);
    chk("glitch_ferr", 32'(ferr), 32'd0);
  endtask

  // Reset in the middle of the third burst frame; lanes already received must be lost
  task automatic reset_seq();
    rxd = 1'b0;
    repeat (BitClks) @(negedge clk);
    rxd = 1'b1;
    repeat (BitClks) @(negedge clk);
    rxd = 1'b0;
    repeat (BitClks) @(negedge clk);
    chk("pre_reset_busy", 32'(rxbusy), 32'd1);
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    chk("mid_reset_q", q, 32'h0);
    chk("mid_reset_busy", 32'(rxbusy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_busy;
    vecs[0]  = mk(PreNone,   1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 0,  32'h00000041, 1, 0, 0);
    vecs[1]  = mk(PreNone,   1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 0,  32'h00000041, 0, 0, 0);
    vecs[2]  = mk(PreNone,   1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 0,  32'h00000041, 0, 0, 0);
    vecs[3]  = mk(PreNone,   1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 0,  32'h00000041, 0, 0, 0);
    vecs[4]  = mk(PreNone,   1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 0,  32'h44434241, 1, 0, 0);
    vecs[5]  = mk(PreNone,   1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 24, 32'h44434241, 0, 0, 1);
    vecs[6]  = mk(PreNone,   1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 0,  32'h00000033, 1, 0, 1);
    vecs[7]  = mk(PreNone,   1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 0,  32'h00000011, 1, 0, 0);
    vecs[8]  = mk(PreNone,   1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 0,  32'h00000022, 1, 1, 0);
    vecs[9]  = mk(PreNone,   1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 0,  32'h00000033, 1, 0, 0);
    vecs[10] = mk(PreGlitch, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 0,  32'h00000033, 0, 0, 0);
    vecs[11] = mk(PreNone,   1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 0,  32'h00000033, 0, 0, 0);
    vecs[12] = mk(PreReset,  1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 0,  32'h00000000, 0, 0, 0);
    vecs[13] = mk(PreNone,   1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 0,  32'h00000000, 0, 0, 0);
    vecs[14] = mk(PreNone,   1'b1, 8'hCC, 1'b1, 1'b0, 1'b0, 0,  32'h00000000, 0, 0, 0);
    vecs[15] = mk(PreNone,   1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 0,  32'hDDCCBBAA, 1, 0, 0);

    reset   = 1'b1;
    rxd     = 1'b1;
    rd      = 1'b0;
    mode    = 1'b0;
    divider = 9'd7;
    repeat (3) @(negedge clk);
    chk("reset_q", q, 32'h0);
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    chk("reset_busy", 32'(rxbusy), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      case (vecs[i].pre)
        PreGlitch: glitch_seq();
        PreReset:  reset_seq();
        default:   ;
      endcase
      sb.push_back(vecs[i].exp);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].rd_at_done);
      if (vecs[i].extra_low > 0) begin
        // Line held in break: no frame may start and no byte may appear
        any_busy = 1'b0;
        rxd      = 1'b0;
        repeat (vecs[i].extra_low) begin
          @(negedge clk);
          any_busy |= rxbusy;
        end
        chk("break_busy", 32'(any_busy), 32'd0);
        chk("break_dv", 32'(dv), 32'd0);
        rxd = 1'b1;
        repeat (BitClks) @(negedge clk);
      end
      if (vecs[i].rd_after) pulse_rd_and_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
